// File: rtl/mix_col_seq.sv
// Sequential AES MixColumns / InvMixColumns / bypass engine.
// Takes a state as four row words and returns four mixed column words, COLS_PER_CYCLE columns per clock.
module mix_col_seq #(
    parameter int COLS_PER_CYCLE = 1,
    parameter int OUT_REG        = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        inv,
    input  logic        bypass,
    input  logic [31:0] row1,
    input  logic [31:0] row2,
    input  logic [31:0] row3,
    input  logic [31:0] row4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] colout1,
    output logic [31:0] colout2,
    output logic [31:0] colout3,
    output logic [31:0] colout4,
    output logic        busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
    if (OUT_REG != 1) begin : g_bad_outreg
        $error("mix_col_seq: OUT_REG must be 1");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    // Counter value of the group that contains column 3.
    localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [3:0][31:0]  row_q, row_d;
    logic [3:0][31:0]  col_q, col_d;
    logic              inv_q, inv_d;
    logic              byp_q, byp_d;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic do_inv,
                                            input logic do_byp);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m3 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m3[i] = x2[i] ^ a[i];
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        if (do_byp)
            return col;
        else if (do_inv)
            return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        else
            return {x2[0] ^ m3[1] ^ a[2]  ^ a[3],
                    a[0]  ^ x2[1] ^ m3[2] ^ a[3],
                    a[0]  ^ a[1]  ^ x2[2] ^ m3[3],
                    m3[0] ^ a[1]  ^ a[2]  ^ x2[3]};
    endfunction

    // Column c is byte (3-c) of each row; ~c selects that byte for a 2-bit index.
    function automatic logic [31:0] get_col(input logic [3:0][31:0] rows, input logic [1:0] c);
        return {rows[0][{~c, 3'b000} +: 8], rows[1][{~c, 3'b000} +: 8],
                rows[2][{~c, 3'b000} +: 8], rows[3][{~c, 3'b000} +: 8]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            inv_q   <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            inv_q   <= inv_d;
            byp_q   <= byp_d;
        end
    end

    always_comb begin
        logic [1:0] c;
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        inv_d   = inv_q;
        byp_d   = byp_q;
        c       = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    row_d   = {row4, row3, row2, row1};
                    inv_d   = inv;
                    byp_d   = bypass;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    c        = cnt_q + 2'(k);
                    col_d[c] = mix_col(get_col(row_q, c), inv_q, byp_q);
                end
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == LAST_GRP)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign colout1   = col_q[0];
    assign colout2   = col_q[1];
    assign colout3   = col_q[2];
    assign colout4   = col_q[3];

endmodule
